// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status, Cause, EPC, BadVAddr,
// Count/Compare timer, exception entry and return sequencing.
module cp0_exc_ctrl #(
  parameter int          NUM_HW_INT   = 5,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           bad_vaddr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  output logic                  exc_taken,
  output logic [31:0]           handler_pc,
  output logic [31:0]           epc,
  output logic                  exl
);

  localparam logic [4:0] A_BVA = 5'd8;
  localparam logic [4:0] A_CNT = 5'd9;
  localparam logic [4:0] A_CMP = 5'd11;
  localparam logic [4:0] A_STS = 5'd12;
  localparam logic [4:0] A_CAU = 5'd13;
  localparam logic [4:0] A_EPC = 5'd14;
  localparam logic [31:0] DIV_LAST = 32'(COUNT_DIV - 1);

  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  tim_q, tim_d;
  logic [NUM_HW_INT-1:0] hw_q;
  logic [1:0]            sw_q, sw_d;
  logic [4:0]            code_q, code_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           bva_q, bva_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           cmp_q, cmp_d;
  logic [31:0]           psc_q, psc_d;

  logic [4:0]  hw5;
  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic        irq_pending;
  logic        wr_sts, wr_cau, wr_cnt;
  logic        wr_cmp, wr_epc;
  logic        bva_code;

  always_comb begin
    hw5 = '0;
    hw5[NUM_HW_INT-1:0] = hw_q;
  end

  assign status_w = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {16'b0, tim_q, hw5, sw_q,
                     1'b0, code_q, 2'b0};

  assign irq_pending = ie_q & ~exl_q
                     & (|(cause_w[15:8] & im_q));
  assign exc_taken   = exc_req | irq_pending;
  assign handler_pc  = HANDLER_ADDR;
  assign epc         = epc_q;
  assign exl         = exl_q;

  assign wr_sts = mtc0_we & (mtc0_addr == A_STS);
  assign wr_cau = mtc0_we & (mtc0_addr == A_CAU);
  assign wr_cnt = mtc0_we & (mtc0_addr == A_CNT);
  assign wr_cmp = mtc0_we & (mtc0_addr == A_CMP);
  assign wr_epc = mtc0_we & (mtc0_addr == A_EPC);
  assign bva_code = (exc_code == 5'd4)
                  | (exc_code == 5'd5);

  always_comb begin
    unique case (mfc0_addr)
      A_BVA:   mfc0_rdata = bva_q;
      A_CNT:   mfc0_rdata = cnt_q;
      A_CMP:   mfc0_rdata = cmp_q;
      A_STS:   mfc0_rdata = status_w;
      A_CAU:   mfc0_rdata = cause_w;
      A_EPC:   mfc0_rdata = epc_q;
      default: mfc0_rdata = 32'h0;
    endcase
  end

  // mtc0 applied first; exception/eret then override shared fields
  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    tim_d  = tim_q;
    sw_d   = sw_q;
    code_d = code_q;
    epc_d  = epc_q;
    bva_d  = bva_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    psc_d  = psc_q;
    if (psc_q >= DIV_LAST) begin
      psc_d = 32'h0;
      cnt_d = cnt_q + 32'd1;
    end else begin
      psc_d = psc_q + 32'd1;
    end
    if (cnt_q == cmp_q) tim_d = 1'b1;
    if (wr_sts) begin
      im_d  = mtc0_wdata[15:8];
      exl_d = mtc0_wdata[1];
      ie_d  = mtc0_wdata[0];
    end
    if (wr_cau) sw_d = mtc0_wdata[9:8];
    if (wr_cnt) begin
      cnt_d = mtc0_wdata;
      psc_d = 32'h0;
    end
    if (wr_cmp) begin
      cmp_d = mtc0_wdata;
      tim_d = 1'b0;
    end
    if (wr_epc) epc_d = mtc0_wdata;
    if (exc_taken) begin
      if (!exl_q) begin
        exl_d = 1'b1;
        epc_d = pc;
      end
      code_d = exc_req ? exc_code : 5'd0;
      if (exc_req && bva_code) bva_d = bad_vaddr;
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      tim_q  <= 1'b0;
      hw_q   <= '0;
      sw_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
      bva_q  <= '0;
      cnt_q  <= '0;
      cmp_q  <= 32'hFFFF_FFFF;
      psc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      tim_q  <= tim_d;
      hw_q   <= hw_int;
      sw_q   <= sw_d;
      code_q <= code_d;
      epc_q  <= epc_d;
      bva_q  <= bva_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      psc_q  <= psc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: vector table through a scoreboard queue,
// plus hand sequences for the timer interrupt and mid-exception reset.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic        eret;
  logic [4:0]  hw_int;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        exc_taken;
  logic [31:0] handler_pc;
  logic [31:0] epc;
  logic        exl;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(
    .NUM_HW_INT(5),
    .COUNT_DIV(2),
    .HANDLER_ADDR(32'h0000_0020)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .exc_req(exc_req), .exc_code(exc_code),
    .bad_vaddr(bad_vaddr), .eret(eret),
    .hw_int(hw_int), .mtc0_we(mtc0_we),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
    .exc_taken(exc_taken), .handler_pc(handler_pc),
    .epc(epc), .exl(exl)
  );

  typedef struct {
    logic        r;
    logic        er;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        eret;
    logic [4:0]  hw;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        t;
    logic        x;
    logic [31:0] e;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          id;
    logic        x;
    logic [31:0] e;
    logic [31:0] rd;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   vid = 0;
  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(
    logic r, logic er, logic [4:0] code,
    logic [31:0] p, logic [31:0] bad,
    logic ert, logic [4:0] hw, logic we,
    logic [4:0] wa, logic [31:0] wd,
    logic [4:0] ra, logic t, logic x,
    logic [31:0] e, logic [31:0] rd);
    vec_t v;
    v.r = r; v.er = er; v.code = code;
    v.pc = p; v.bad = bad; v.eret = ert;
    v.hw = hw; v.we = we; v.wa = wa;
    v.wd = wd; v.ra = ra; v.t = t;
    v.x = x; v.e = e; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Called and returns just after a negedge
  task automatic step(input vec_t v);
    exp_t x;
    rst        = v.r;
    exc_req    = v.er;
    exc_code   = v.code;
    pc         = v.pc;
    bad_vaddr  = v.bad;
    eret       = v.eret;
    hw_int     = v.hw;
    mtc0_we    = v.we;
    mtc0_addr  = v.wa;
    mtc0_wdata = v.wd;
    #1;
    chk($sformatf("v%0d taken", vid),
        {31'b0, exc_taken}, {31'b0, v.t});
    x.id = vid; x.x = v.x; x.e = v.e; x.rd = v.rd;
    sb.push_back(x);
    @(posedge clk);
    #1;
    mfc0_addr = v.ra;
    #1;
    x = sb.pop_front();
    chk($sformatf("v%0d exl", x.id),
        {31'b0, exl}, {31'b0, x.x});
    chk($sformatf("v%0d epc", x.id), epc, x.e);
    chk($sformatf("v%0d rdata", x.id),
        mfc0_rdata, x.rd);
    vid++;
    @(negedge clk);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b1; exc_req = 0; exc_code = 0;
    pc = 0; bad_vaddr = 0; eret = 0;
    hw_int = 0; mtc0_we = 0; mtc0_addr = 0;
    mtc0_wdata = 0; mfc0_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //           r er cd pc      bad      ert hw we wa  wd           ra  t x  epc      rdata
    tbl.push_back(mk(1,0,0,32'h0,  32'h0,   0,0,0,0, 32'h0,       11, 0,0,32'h0,  32'hFFFF_FFFF));
    tbl.push_back(mk(0,1,8,32'h100,32'h0,   0,0,0,0, 32'h0,       13, 1,1,32'h100,32'h20));
    tbl.push_back(mk(0,0,0,32'h104,32'h0,   1,0,0,0, 32'h0,       12, 0,0,32'h100,32'h0));
    tbl.push_back(mk(0,0,0,32'h108,32'h0,   0,0,1,12,32'h401,     12, 0,0,32'h100,32'h401));
    tbl.push_back(mk(0,0,0,32'h200,32'h0,   0,1,0,0, 32'h0,       13, 0,0,32'h100,32'h420));
    tbl.push_back(mk(0,0,0,32'h204,32'h0,   0,1,0,0, 32'h0,       13, 1,1,32'h204,32'h400));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,1,0,0, 32'h0,       12, 0,1,32'h204,32'h403));
    tbl.push_back(mk(0,1,4,32'h300,32'hDEAD,0,0,0,0, 32'h0,       8,  1,1,32'h204,32'hDEAD));
    tbl.push_back(mk(0,0,0,32'h24,32'h0,    0,0,0,0, 32'h0,       13, 0,1,32'h204,32'h10));
    tbl.push_back(mk(0,1,8,32'h304,32'hBEEF,0,0,0,0, 32'h0,       8,  1,1,32'h204,32'hDEAD));
    tbl.push_back(mk(0,0,0,32'h28,32'h0,    1,0,1,13,32'h300,     13, 0,0,32'h204,32'h320));
    tbl.push_back(mk(0,0,0,32'h2C,32'h0,    0,0,1,12,32'h301,     12, 0,0,32'h204,32'h301));
    tbl.push_back(mk(0,0,0,32'h400,32'h0,   0,0,0,0, 32'h0,       13, 1,1,32'h400,32'h300));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,1,12,32'h0,       12, 0,0,32'h400,32'h0));
    tbl.push_back(mk(0,0,0,32'h24,32'h0,    0,0,1,12,32'hFF01,    12, 0,0,32'h400,32'hFF01));
    tbl.push_back(mk(0,1,10,32'h500,32'h0,  1,0,1,12,32'h0,       12, 1,1,32'h500,32'h2));
    tbl.push_back(mk(0,0,0,32'h504,32'h0,   0,0,1,7, 32'h1234,    7,  0,1,32'h500,32'h0));
    tbl.push_back(mk(0,0,0,32'h508,32'h0,   0,0,1,9, 32'd100,     9,  0,1,32'h500,32'd100));
    tbl.push_back(mk(0,0,0,32'h50C,32'h0,   0,0,1,14,32'hABC,     14, 0,1,32'hABC,32'hABC));
    tbl.push_back(mk(0,0,0,32'h510,32'h0,   0,0,1,8, 32'h1,       8,  0,1,32'hABC,32'hDEAD));
    tbl.push_back(mk(0,0,0,32'h514,32'h0,   0,0,1,13,32'h0,       10, 0,1,32'hABC,32'h0));
    run_tbl();
    chk("handler_pc", handler_pc, 32'h20);

    // Reset while inside a handler, with a same-cycle exception
    tbl.push_back(mk(1,1,8,32'h700,32'h0,   0,0,0,0, 32'h0,       11, 1,0,32'h0,  32'hFFFF_FFFF));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,0,0, 32'h0,       9,  0,0,32'h0,  32'h0));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,0,0, 32'h0,       12, 0,0,32'h0,  32'h0));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,0,0, 32'h0,       8,  0,0,32'h0,  32'h0));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,0,0, 32'h0,       13, 0,0,32'h0,  32'h0));
    // Timer: Compare=5, IM7 + IE
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,1,11,32'd5,       11, 0,0,32'h0,  32'd5));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,1,12,32'h8001,    12, 0,0,32'h0,  32'h8001));
    run_tbl();

    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exc_req = 0; eret = 0; mtc0_we = 0;
      pc = 32'h600; mfc0_addr = 5'd13;
      #1;
      if (mfc0_rdata[15]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("timer_ip_seen", {31'b0, found}, 32'h1);
    chk("timer_irq_taken",
        {31'b0, exc_taken}, 32'h1);

    tbl.push_back(mk(0,0,0,32'h600,32'h0,   0,0,0,0, 32'h0,       13, 1,1,32'h600,32'h8000));
    tbl.push_back(mk(0,0,0,32'h20,32'h0,    0,0,1,11,32'h1000,    13, 0,1,32'h600,32'h0));
    run_tbl();

    chk("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
